// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore sequencing FSM that steps the shared
// datapath one phase per clock, stretches memory phases until the memory
// reports ready, parks in HALT on illegal encodings and counts retired
// instructions.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic [3:0]       alu_control,
   output logic [3:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_ADDI_EXEC = 4'd9,
      S_ADDI_WB   = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd15
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;
   logic             w_retire;
   logic             w_funct_ok;
   logic [3:0]       w_funct_alu;

   // Ungated control values decoded from the current state.
   logic       w_pc_en, w_iord, w_mem_read, w_mem_write, w_ir_write;
   logic       w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_halted;
   logic [1:0] w_alu_src_b, w_pc_src;
   logic [3:0] w_alu_control;

   // R-type function decode: legality and the ALU operation it selects.
   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = 4'b0000;
      unique case (funct)
         6'd32:   w_funct_alu = 4'b0010;
         6'd34:   w_funct_alu = 4'b0110;
         6'd36:   w_funct_alu = 4'b0000;
         6'd37:   w_funct_alu = 4'b0001;
         6'd39:   w_funct_alu = 4'b1100;
         6'd42:   w_funct_alu = 4'b0111;
         default: w_funct_ok  = 1'b0;
      endcase
   end

   // State register; reset returns to FETCH at once, even mid-instruction.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Retired-instruction counter, advanced on the edge leaving a final state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)        r_count <= '0;
      else if (w_retire) r_count <= r_count + CNT_W'(1);
   end

   // Next-state and per-state control decode.
   always_comb begin
      // NOTE: every output gets a default before the case so no path
      // through this block leaves a value held, which would infer a latch.
      w_next        = r_state;
      w_retire      = 1'b0;
      w_pc_en       = 1'b0;
      w_iord        = 1'b0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_ir_write    = 1'b0;
      w_reg_dst     = 1'b0;
      w_mem_to_reg  = 1'b0;
      w_reg_write   = 1'b0;
      w_alu_src_a   = 1'b0;
      w_alu_src_b   = 2'b00;
      w_pc_src      = 2'b00;
      w_alu_control = 4'b0000;
      w_halted      = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            w_mem_read    = 1'b1;
            w_alu_src_b   = 2'b01;
            w_alu_control = 4'b0010;
            w_ir_write    = mem_ready;
            w_pc_en       = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            // Speculatively form the branch target into ALUOut.
            w_alu_src_b   = 2'b11;
            w_alu_control = 4'b0010;
            unique case (opcode)
               6'd0:        w_next = w_funct_ok ? S_EXECUTE : S_HALT;
               6'd35, 6'd43: w_next = S_MEM_ADDR;
               6'd4:        w_next = S_BRANCH;
               6'd8:        w_next = S_ADDI_EXEC;
               6'd2:        w_next = S_JUMP;
               default:     w_next = S_HALT;
            endcase
         end
         S_MEM_ADDR: begin
            w_alu_src_a   = 1'b1;
            w_alu_src_b   = 2'b10;
            w_alu_control = 4'b0010;
            w_next        = (opcode == 6'd35) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
            if (mem_ready) w_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_retire     = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEM_WRITE: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
            if (mem_ready) begin
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end
         end
         S_EXECUTE: begin
            w_alu_src_a   = 1'b1;
            w_alu_control = w_funct_alu;
            w_next        = S_ALU_WB;
         end
         S_ALU_WB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a   = 1'b1;
            w_alu_control = 4'b0110;
            w_pc_src      = 2'b01;
            w_pc_en       = zero;
            w_retire      = 1'b1;
            w_next        = S_FETCH;
         end
         S_ADDI_EXEC: begin
            w_alu_src_a   = 1'b1;
            w_alu_src_b   = 2'b10;
            w_alu_control = 4'b0010;
            w_next        = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
         end
         S_JUMP: begin
            w_pc_src = 2'b10;
            w_pc_en  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
         end
         S_HALT: begin
            w_halted = 1'b1;
         end
         default: begin
            // Unused encodings are treated as illegal and park the FSM.
            w_next = S_HALT;
         end
      endcase
   end

   // While reset is held every control output is silenced, not just the
   // registered state, so the datapath sees no FETCH strobes during reset.
   always_comb begin
      pc_en       = reset & w_pc_en;
      iord        = reset & w_iord;
      mem_read    = reset & w_mem_read;
      mem_write   = reset & w_mem_write;
      ir_write    = reset & w_ir_write;
      reg_dst     = reset & w_reg_dst;
      mem_to_reg  = reset & w_mem_to_reg;
      reg_write   = reset & w_reg_write;
      alu_src_a   = reset & w_alu_src_a;
      alu_src_b   = reset ? w_alu_src_b : 2'b00;
      pc_src      = reset ? w_pc_src : 2'b00;
      alu_control = reset ? w_alu_control : 4'b0000;
      halted      = reset & w_halted;
      state       = r_state;
      instr_count = r_count;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencing FSM for the multicycle MIPS datapath. It drives the existing ALU, RegFile, Memory and ProgramCounter, plus the IR/mux registers around them, one instruction step per clock.
- It replaces the single-cycle MainDecoder/ALUDecoder pairing.
- It adds memory wait states, halts on illegal encodings, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock; state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access complete this cycle.
- pc_en  output  1  ProgramCounter load enable.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  Memory ren.
- mem_write  output  1  Memory wen.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  write address select: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data select: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  RegFile wen.
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  output  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_control  output  4  ALU op code.
- state  output  4  current state, for debug.
- halted  output  1  FSM is in HALT.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, ADDI_EXEC=9, ADDI_WB=10, JUMP=11, HALT=15.
- Reset low, at any time including mid-instruction:
  - state=FETCH and instr_count=0 immediately.
  - All enables (pc_en, ir_write, mem_read, mem_write, reg_write) forced to 0 while reset is low.
  - Mux selects and alu_control are 0; halted=0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=0010, pc_src=00.
  - If mem_ready=1: ir_write=1, pc_en=1, go to DECODE.
  - Else: stay, with ir_write=0 and pc_en=0.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_control=0010 (branch target into ALUOut).
  - Next state by opcode:
    - 0 → EXECUTE if funct is legal, else HALT.
    - 35 or 43 → MEM_ADDR.
    - 4 → BRANCH.
    - 8 → ADDI_EXEC.
    - 2 → JUMP.
    - any other → HALT.
  - Legal funct values: 32, 34, 36, 37, 39, 42.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_control=0010. Go to MEM_READ if opcode=35, else MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retire, then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Wait for mem_ready, then retire and go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00. alu_control by funct:
  - 32 → 0010
  - 34 → 0110
  - 36 → 0000
  - 37 → 0001
  - 39 → 1100
  - 42 → 0111
  - Next state: ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_control=0110, pc_src=01.
  - pc_en = zero (combinational on zero).
  - Retire, then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_control=0010, then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire, then FETCH.
- JUMP: pc_src=10, pc_en=1. Retire, then FETCH.
- HALT:
  - All enables 0, halted=1.
  - Held until reset; instr_count frozen.
  - The illegal instruction is not counted.
- Retire: instr_count increments by 1 on the clock edge leaving the final state of an instruction. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory: beq 3 cycles, j 3, R-type 4, sw 4, addi 4, lw 5. Each memory wait cycle adds 1.
- Output qualification:
  - All outputs not listed for a state are 0.
  - Outputs are decoded from registered state. The only exceptions are the mem_ready and zero qualifications on pc_en and ir_write.
  - mem_read and mem_write are never both 1.

Test Plan:
- Reset, then opcode=0, funct=32, mem_ready=1 → states 0,1,6,7,0. alu_control=0010 in EXECUTE; reg_write=1 and reg_dst=1 in ALU_WB; instr_count=1.
- lw (opcode 35) with mem_ready low for 2 cycles in MEM_READ → states 0,1,2,3,3,3,4,0. mem_to_reg=1 in MEM_WB; total 7 cycles.
- beq (opcode 4): zero=1 → pc_en=1 with pc_src=01 in BRANCH. Repeat with zero=0 → pc_en=0. instr_count increments in both cases.
- opcode=63, or opcode=0 with funct=0 → HALT after DECODE. halted=1, all enables 0 for 10+ cycles, instr_count unchanged.
- reset pulsed low during MEM_WRITE → mem_write drops to 0 immediately, state=0, instr_count=0. Normal fetch resumes after release.
- sw, addi, j in sequence → state paths 0,1,2,5,0 / 0,1,9,10,0 / 0,1,11,0. instr_count=3.
